// File: rtl/ctrl_pkg.sv
// Shared encodings for the down-sampler sequencer: opcodes, register codes,
// ALU controls, instruction field positions and FSM states.
package ctrl_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_MOV   = 4'h2;
    localparam logic [3:0] OP_ALU   = 4'h3;
    localparam logic [3:0] OP_CMP   = 4'h4;
    localparam logic [3:0] OP_LOAD  = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JG    = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] REG_NONE = 3'd0;
    localparam logic [2:0] REG_PC   = 3'd1;
    localparam logic [2:0] REG_DR   = 3'd2;
    localparam logic [2:0] REG_R1   = 3'd3;
    localparam logic [2:0] REG_R2   = 3'd4;
    localparam logic [2:0] REG_R3   = 3'd5;
    localparam logic [2:0] REG_R4   = 3'd6;
    localparam logic [2:0] REG_R5   = 3'd7;

    localparam logic [2:0] ALU_PASSA = 3'd0;
    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] ALU_SUB   = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_SHL   = 3'd5;
    localparam logic [2:0] ALU_SHR   = 3'd6;
    localparam logic [2:0] ALU_PASSB = 3'd7;

    localparam int OP_LSB    = 12;
    localparam int RD_LSB    = 9;
    localparam int RA_LSB    = 6;
    localparam int RB_LSB    = 3;
    localparam int FUNCT_LSB = 0;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_FWAIT  = 4'd1,
        S_DECODE = 4'd2,
        S_IMM_F  = 4'd3,
        S_IMM_W  = 4'd4,
        S_EXEC   = 4'd5,
        S_MEM1   = 4'd6,
        S_MEM2   = 4'd7,
        S_MEM3   = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP      = 3'd0,
        CLS_TWO_WORD = 3'd1,
        CLS_MEM      = 3'd2,
        CLS_EXEC     = 3'd3,
        CLS_HALT     = 3'd4
    } op_class_t;

    function automatic logic [2:0] field3(input logic [15:0] word, input int lsb);
        return word[lsb +: 3];
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction/flag inputs and datapath control lines between the sequencer
// (master) and the down-sampler datapath (slave).
interface control_unit_if;
    logic [15:0] instr;
    logic        zero;
    logic        great;
    logic [2:0]  sel_d;
    logic [2:0]  flagA;
    logic [2:0]  flagB;
    logic [2:0]  ctrl;
    logic        sel_c;
    logic [15:0] constant;
    logic        incr_en;
    logic        ir_en;
    logic        merge_en;
    logic        d_RAM_en;
    logic        halted;

    modport master (
        input  instr, zero, great,
        output sel_d, flagA, flagB, ctrl, sel_c, constant,
        output incr_en, ir_en, merge_en, d_RAM_en, halted
    );

    modport slave (
        output instr, zero, great,
        input  sel_d, flagA, flagB, ctrl, sel_c, constant,
        input  incr_en, ir_en, merge_en, d_RAM_en, halted
    );
endinterface

// File: rtl/ctrl_decode.sv
// Opcode classifier: picks which state sequence follows S_DECODE.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] op,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CLS_HALT;
        case (op)
            OP_NOP:                  op_class = CLS_NOP;
            OP_LDI, OP_JMP,
            OP_JZ, OP_JG:            op_class = CLS_TWO_WORD;
            OP_LOAD, OP_STORE:       op_class = CLS_MEM;
            OP_MOV, OP_ALU, OP_CMP:  op_class = CLS_EXEC;
            // HALT and the unassigned opcodes A-E all park the machine
            default:                 op_class = CLS_HALT;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer. Outputs are a Moore decode of the
// state register and the instruction fields latched in S_DECODE.
module control_unit
    import ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    control_unit_if.master  bus
);

    state_t     state_reg;
    logic [3:0] op_reg;
    logic [2:0] rd_reg;
    logic [2:0] ra_reg;
    logic [2:0] rb_reg;
    logic [2:0] funct_reg;
    logic       z_f_reg;
    logic       g_f_reg;

    op_class_t  op_class;

    ctrl_decode u_decode (
        .op       (bus.instr[OP_LSB +: 4]),
        .op_class (op_class)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            op_reg    <= OP_NOP;
            rd_reg    <= REG_NONE;
            ra_reg    <= REG_NONE;
            rb_reg    <= REG_NONE;
            funct_reg <= ALU_PASSA;
            z_f_reg   <= 1'b0;
            g_f_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH:  state_reg <= S_FWAIT;
                S_FWAIT:  state_reg <= S_DECODE;
                S_DECODE: begin
                    op_reg    <= bus.instr[OP_LSB +: 4];
                    rd_reg    <= field3(bus.instr, RD_LSB);
                    ra_reg    <= field3(bus.instr, RA_LSB);
                    rb_reg    <= field3(bus.instr, RB_LSB);
                    funct_reg <= field3(bus.instr, FUNCT_LSB);
                    case (op_class)
                        CLS_NOP:      state_reg <= S_FETCH;
                        CLS_TWO_WORD: state_reg <= S_IMM_F;
                        CLS_MEM:      state_reg <= S_MEM1;
                        CLS_EXEC:     state_reg <= S_EXEC;
                        default:      state_reg <= S_HALT;
                    endcase
                end
                S_IMM_F:  state_reg <= S_IMM_W;
                S_IMM_W:  state_reg <= S_EXEC;
                S_EXEC: begin
                    // Flags are captured only by CMP so jumps see the last compare
                    if (op_reg == OP_CMP) begin
                        z_f_reg <= bus.zero;
                        g_f_reg <= bus.great;
                    end
                    state_reg <= S_FETCH;
                end
                S_MEM1:   state_reg <= S_MEM2;
                S_MEM2:   state_reg <= (op_reg == OP_LOAD) ? S_MEM3 : S_FETCH;
                S_MEM3:   state_reg <= S_FETCH;
                S_HALT:   state_reg <= S_HALT;
                default:  state_reg <= S_HALT;
            endcase
        end
    end

    logic        take_jump;
    logic [2:0]  sel_d;
    logic [2:0]  flag_a;
    logic [2:0]  flag_b;
    logic [2:0]  ctrl;
    logic        sel_c;
    logic [15:0] constant;
    logic        incr_en;
    logic        ir_en;
    logic        merge_en;
    logic        d_ram_en;
    logic        halted;

    assign take_jump = (op_reg == OP_JMP) ||
                       ((op_reg == OP_JZ) && z_f_reg) ||
                       ((op_reg == OP_JG) && g_f_reg);

    always_comb begin
        sel_d    = REG_NONE;
        flag_a   = REG_NONE;
        flag_b   = REG_NONE;
        ctrl     = ALU_PASSA;
        sel_c    = 1'b0;
        constant = 16'h0000;
        incr_en  = 1'b0;
        ir_en    = 1'b0;
        merge_en = 1'b0;
        d_ram_en = 1'b0;
        halted   = 1'b0;
        case (state_reg)
            S_FWAIT, S_IMM_W: begin
                ir_en   = 1'b1;
                incr_en = 1'b1;
            end
            S_EXEC: begin
                case (op_reg)
                    OP_MOV: begin
                        flag_a = ra_reg;
                        ctrl   = ALU_PASSA;
                        sel_d  = rd_reg;
                    end
                    OP_ALU: begin
                        flag_a = ra_reg;
                        flag_b = rb_reg;
                        ctrl   = funct_reg;
                        sel_d  = rd_reg;
                    end
                    OP_CMP: begin
                        flag_a = ra_reg;
                        flag_b = rb_reg;
                        ctrl   = ALU_SUB;
                    end
                    // In S_EXEC the IR already holds the immediate word
                    OP_LDI: begin
                        sel_c    = 1'b1;
                        constant = bus.instr;
                        sel_d    = rd_reg;
                    end
                    OP_JMP, OP_JZ, OP_JG: begin
                        if (take_jump) begin
                            sel_c    = 1'b1;
                            constant = bus.instr;
                            sel_d    = REG_PC;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEM1:  merge_en = 1'b1;
            S_MEM2:  d_ram_en = (op_reg == OP_STORE);
            S_MEM3:  sel_d    = REG_DR;
            S_HALT:  halted   = 1'b1;
            default: ;
        endcase
    end

    assign bus.sel_d    = sel_d;
    assign bus.flagA    = flag_a;
    assign bus.flagB    = flag_b;
    assign bus.ctrl     = ctrl;
    assign bus.sel_c    = sel_c;
    assign bus.constant = constant;
    assign bus.incr_en  = incr_en;
    assign bus.ir_en    = ir_en;
    assign bus.merge_en = merge_en;
    assign bus.d_RAM_en = d_ram_en;
    assign bus.halted   = halted;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a per-instruction cycle model queues the
// expected output vector of every cycle; a negedge monitor pops and compares.
module tb_control_unit;
    import ctrl_pkg::*;

    typedef struct packed {
        logic [2:0]  sel_d;
        logic [2:0]  flag_a;
        logic [2:0]  flag_b;
        logic [2:0]  ctrl;
        logic        sel_c;
        logic [15:0] constant;
        logic        incr_en;
        logic        ir_en;
        logic        merge_en;
        logic        d_ram_en;
        logic        halted;
    } outs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_unit_if bus ();

    control_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    outs_t exp_q [$];
    string tag_q [$];
    int    vectors = 0;
    int    miscompares = 0;

    logic [15:0] ir_val;
    logic        zf, gf;
    logic        force_en, force_z, force_g;

    function automatic outs_t sample();
        outs_t s;
        s.sel_d    = bus.sel_d;
        s.flag_a   = bus.flagA;
        s.flag_b   = bus.flagB;
        s.ctrl     = bus.ctrl;
        s.sel_c    = bus.sel_c;
        s.constant = bus.constant;
        s.incr_en  = bus.incr_en;
        s.ir_en    = bus.ir_en;
        s.merge_en = bus.merge_en;
        s.d_ram_en = bus.d_RAM_en;
        s.halted   = bus.halted;
        return s;
    endfunction

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb,
                                       input logic [2:0] fn);
        return {op, rd, ra, rb, fn};
    endfunction

    task automatic check_now(input string name, input outs_t e);
        outs_t a;
        a = sample();
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    // Monitor: one expected vector per cycle, compared mid-cycle
    initial begin
        outs_t e, a;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = sample();
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h", t, a, e);
                end
            end
        end
    end

    task automatic step(input logic [15:0] iv, input outs_t e, input string tag,
                        output logic z, output logic g);
        z = force_en ? force_z : 1'($urandom_range(0, 1));
        g = force_en ? force_g : 1'($urandom_range(0, 1));
        bus.instr = iv;
        bus.zero  = z;
        bus.great = g;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected per-cycle outputs derived from the opcode's
    // cycle schedule and the IR contents the datapath would present.
    task automatic issue(input logic [15:0] w, input logic [15:0] imm,
                         input string tag, input int halt_cycles);
        logic [3:0] op;
        logic [2:0] rd, ra, rb, fn;
        logic       z, g, taken;
        outs_t      idle, e;
        op = w[15:12]; rd = w[11:9]; ra = w[8:6]; rb = w[5:3]; fn = w[2:0];
        idle = '0;
        $display("instr %-10s word=%h imm=%h zf=%0d gf=%0d", tag, w, imm, zf, gf);
        step(ir_val, idle, {tag, ":fetch"}, z, g);
        e = idle; e.ir_en = 1'b1; e.incr_en = 1'b1;
        step(ir_val, e, {tag, ":fwait"}, z, g);
        ir_val = w;
        step(ir_val, idle, {tag, ":decode"}, z, g);
        case (op)
            4'h0: ;
            4'h1, 4'h7, 4'h8, 4'h9: begin
                step(ir_val, idle, {tag, ":imm_f"}, z, g);
                e = idle; e.ir_en = 1'b1; e.incr_en = 1'b1;
                step(ir_val, e, {tag, ":imm_w"}, z, g);
                ir_val = imm;
                taken = (op == 4'h1) || (op == 4'h7) || (op == 4'h8 && zf) || (op == 4'h9 && gf);
                e = idle;
                if (taken) begin
                    e.sel_c = 1'b1;
                    e.constant = imm;
                    e.sel_d = (op == 4'h1) ? rd : REG_PC;
                end
                step(ir_val, e, {tag, ":exec"}, z, g);
            end
            4'h2: begin
                e = idle; e.flag_a = ra; e.ctrl = ALU_PASSA; e.sel_d = rd;
                step(ir_val, e, {tag, ":exec"}, z, g);
            end
            4'h3: begin
                e = idle; e.flag_a = ra; e.flag_b = rb; e.ctrl = fn; e.sel_d = rd;
                step(ir_val, e, {tag, ":exec"}, z, g);
            end
            4'h4: begin
                e = idle; e.flag_a = ra; e.flag_b = rb; e.ctrl = ALU_SUB;
                step(ir_val, e, {tag, ":exec"}, z, g);
                zf = z;
                gf = g;
            end
            4'h5: begin
                e = idle; e.merge_en = 1'b1;
                step(ir_val, e, {tag, ":mem1"}, z, g);
                step(ir_val, idle, {tag, ":mem2"}, z, g);
                e = idle; e.sel_d = REG_DR;
                step(ir_val, e, {tag, ":mem3"}, z, g);
            end
            4'h6: begin
                e = idle; e.merge_en = 1'b1;
                step(ir_val, e, {tag, ":mem1"}, z, g);
                e = idle; e.d_ram_en = 1'b1;
                step(ir_val, e, {tag, ":mem2"}, z, g);
            end
            default: begin
                e = idle; e.halted = 1'b1;
                for (int i = 0; i < halt_cycles; i++)
                    step(ir_val, e, {tag, ":halt"}, z, g);
            end
        endcase
    endtask

    task automatic apply_reset(input string tag);
        outs_t zero_outs;
        zero_outs = '0;
        rst_n = 1'b0;
        #1;
        check_now({tag, ":outs"}, zero_outs);
        vectors++;
        if (u_dut.state_reg !== S_FETCH) begin
            miscompares++;
            $display("FAIL %s:state got %0d expected %0d", tag, u_dut.state_reg, S_FETCH);
        end
        @(posedge clk);
        #1;
        check_now({tag, ":held"}, zero_outs);
        rst_n = 1'b1;
        zf = 1'b0;
        gf = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        outs_t e;
        logic z, g;
        logic [3:0] op;
        ir_val = 16'h0000;
        zf = 1'b0; gf = 1'b0;
        force_en = 1'b0; force_z = 1'b0; force_g = 1'b0;
        bus.instr = 16'h0000; bus.zero = 1'b0; bus.great = 1'b0;

        @(posedge clk); #1;
        check_now("reset_initial", '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // STORE aborted by reset while in S_MEM1
        $display("instr %-10s word=%h (reset in mem1)", "store_rst", mk(OP_STORE, 0, 0, 0, 0));
        step(ir_val, '0, "store_rst:fetch", z, g);
        e = '0; e.ir_en = 1'b1; e.incr_en = 1'b1;
        step(ir_val, e, "store_rst:fwait", z, g);
        ir_val = mk(OP_STORE, 0, 0, 0, 0);
        step(ir_val, '0, "store_rst:decode", z, g);
        bus.instr = ir_val;
        e = '0; e.merge_en = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back("store_rst:mem1");
        @(negedge clk); #1;
        apply_reset("reset_mid_store");
        issue(mk(OP_NOP, 0, 0, 0, 0), 16'h0, "nop_post", 0);
        issue(mk(OP_NOP, 0, 0, 0, 0), 16'h0, "nop_post2", 0);

        // Directed program
        issue(mk(OP_LDI, REG_R1, 0, 0, 0), 16'h00A5, "ldi", 0);
        issue(mk(OP_MOV, REG_R3, REG_R1, 0, 0), 16'h0, "mov", 0);
        force_en = 1'b1; force_z = 1'b1; force_g = 1'b0;
        issue(mk(OP_CMP, 0, REG_R1, REG_R2, 0), 16'h0, "cmp_z1", 0);
        force_en = 1'b0;
        issue(mk(OP_JZ, 0, 0, 0, 0), 16'h0040, "jz_taken", 0);
        force_en = 1'b1; force_z = 1'b0; force_g = 1'b1;
        issue(mk(OP_CMP, 0, REG_R1, REG_R2, 0), 16'h0, "cmp_z0", 0);
        force_en = 1'b0;
        issue(mk(OP_JZ, 0, 0, 0, 0), 16'h0040, "jz_untaken", 0);
        issue(mk(OP_JG, 0, 0, 0, 0), 16'h0077, "jg_taken", 0);
        issue(mk(OP_LOAD, 0, 0, 0, 0), 16'h0, "load", 0);
        issue(mk(OP_STORE, 0, 0, 0, 0), 16'h0, "store", 0);
        issue(mk(OP_ALU, REG_R4, REG_R1, REG_R2, ALU_ADD), 16'h0, "alu_add", 0);
        issue(mk(OP_ALU, REG_NONE, REG_R1, REG_R2, ALU_ADD), 16'h0, "alu_rd0", 0);
        issue(mk(OP_MOV, REG_PC, REG_R5, 0, 0), 16'h0, "mov_pc", 0);
        issue(mk(OP_JMP, 0, 0, 0, 0), 16'h1234, "jmp", 0);

        // Randomized legal instruction stream
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 9));
            issue(mk(op, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom)),
                  16'($urandom), $sformatf("rnd%0d", i), 0);
        end

        // Illegal opcode parks the machine; it must stay idle apart from halted
        issue(mk(4'hB, 3'd5, 3'd3, 3'd4, 3'd1), 16'h0, "illegal_b", 21);
        apply_reset("reset_from_halt");
        issue(mk(OP_NOP, 0, 0, 0, 0), 16'h0, "nop_after", 0);
        issue(mk(OP_HALT, 0, 0, 0, 0), 16'h0, "halt", 4);

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
